// File: rtl/crc_pkg.sv
// Shared types, bit-reversal helpers and common CRC parameter presets
// for the parallel CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_EMIT = 2'd2
   } crc_state_e;

   typedef struct packed {
      logic [5:0]  width;
      logic [31:0] poly;
      logic [31:0] init;
      logic [31:0] xor_out;
      logic        refl_in;
      logic        refl_out;
   } crc_preset_t;

   localparam crc_preset_t CRC16_CCITT_FALSE = '{
      width: 6'd16, poly: 32'h0000_1021, init: 32'h0000_FFFF,
      xor_out: 32'h0000_0000, refl_in: 1'b0, refl_out: 1'b0};

   localparam crc_preset_t CRC16_XMODEM = '{
      width: 6'd16, poly: 32'h0000_1021, init: 32'h0000_0000,
      xor_out: 32'h0000_0000, refl_in: 1'b0, refl_out: 1'b0};

   localparam crc_preset_t CRC32_IEEE = '{
      width: 6'd32, poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
      xor_out: 32'hFFFF_FFFF, refl_in: 1'b1, refl_out: 1'b1};

   // Bit-reverse one byte.
   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int unsigned i = 0; i < 8; i++) begin
         r[3'(i)] = b[3'(7 - i)];
      end
      return r;
   endfunction

   // Bit-reverse the low w bits of x (w <= 32); upper result bits are zero.
   function automatic logic [31:0] rev_w(input logic [31:0] x, input int unsigned w);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < w) begin
            r[5'(i)] = x[5'(w - 1 - i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_parallel_step.sv
// Combinational CRC fold of one DATA_W word: bytes MSB first, each byte
// MSB-bit first after optional per-byte reflection.
module crc_parallel_step
   import crc_pkg::*;
#(
   parameter int unsigned       CRC_W      = 16,
   parameter int unsigned       DATA_W     = 8,
   parameter logic [CRC_W-1:0]  POLY       = 16'h1021,
   parameter bit                REFLECT_IN = 1'b0
) (
   input  logic [CRC_W-1:0]  crc_in,
   input  logic [DATA_W-1:0] data,
   output logic [CRC_W-1:0]  crc_next
);

   localparam int unsigned NBYTES = DATA_W / 8;

   always_comb begin
      logic [CRC_W-1:0] c;
      logic [7:0]       b;
      logic             fb;
      c  = crc_in;
      b  = '0;
      fb = 1'b0;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         b = 8'(data >> (DATA_W - 8 - 8 * k));
         if (REFLECT_IN) begin
            b = rev8(b);
         end
         for (int unsigned j = 0; j < 8; j++) begin
            fb = c[CRC_W-1] ^ b[7];
            b  = {b[6:0], 1'b0};
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
         end
      end
      crc_next = c;
   end

endmodule

// File: rtl/crc_parallel_gen.sv
// Parametrised parallel CRC engine: folds framed DATA_W-bit input words and
// streams the finished CRC out MSB chunk first in OUT_W-bit pieces.
module crc_parallel_gen
   import crc_pkg::*;
#(
   parameter int unsigned       CRC_W       = 16,
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       OUT_W       = 8,
   parameter logic [CRC_W-1:0]  POLY        = 16'h1021,
   parameter logic [CRC_W-1:0]  INIT        = 16'hFFFF,
   parameter logic [CRC_W-1:0]  XOR_OUT     = 16'h0000,
   parameter bit                REFLECT_IN  = 1'b0,
   parameter bit                REFLECT_OUT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic [CRC_W-1:0]  crc_value
);

   localparam int unsigned NCHUNK = CRC_W / OUT_W;
   localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

   crc_state_e       state;
   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_step;
   logic [CRC_W-1:0] result;
   logic [CRC_W-1:0] shreg;
   logic [CRC_W-1:0] shreg_next;
   logic [CNT_W-1:0] chunk_cnt;
   logic [CNT_W-1:0] chunk_cnt_inc;

   crc_parallel_step #(
      .CRC_W      (CRC_W),
      .DATA_W     (DATA_W),
      .POLY       (POLY),
      .REFLECT_IN (REFLECT_IN)
   ) u_step (
      .crc_in   (crc_q),
      .data     (in_data),
      .crc_next (crc_step)
   );

   // Final result of the frame if the current beat is its last one.
   always_comb begin
      result = crc_step;
      if (REFLECT_OUT) begin
         result = CRC_W'(rev_w(32'(crc_step), CRC_W));
      end
      result        = result ^ XOR_OUT;
      shreg_next    = shreg << OUT_W;
      chunk_cnt_inc = CNT_W'(chunk_cnt + 1'b1);
   end

   assign out_data  = shreg[CRC_W-1 -: OUT_W];
   assign crc_value = crc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         crc_q     <= INIT;
         shreg     <= '0;
         chunk_cnt <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  crc_q    <= INIT;
                  state    <= ST_RUN;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end

            // A restart wins over any beat presented in the same cycle.
            ST_RUN: begin
               if (start) begin
                  crc_q <= INIT;
               end else if (in_valid && in_ready) begin
                  crc_q <= crc_step;
                  if (in_last) begin
                     shreg     <= result;
                     chunk_cnt <= '0;
                     out_valid <= 1'b1;
                     out_last  <= (NCHUNK == 1);
                     in_ready  <= 1'b0;
                     state     <= ST_EMIT;
                  end
               end
            end

            ST_EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     shreg     <= '0;
                     if (start) begin
                        crc_q    <= INIT;
                        in_ready <= 1'b1;
                        state    <= ST_RUN;
                     end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                     end
                  end else begin
                     shreg     <= shreg_next;
                     chunk_cnt <= chunk_cnt_inc;
                     out_last  <= (chunk_cnt_inc == LAST_IDX);
                  end
               end
            end

            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc_parallel_gen.sv
// Scoreboard bench for crc_parallel_gen: CCITT-FALSE, XMODEM, CRC-32 and a
// 16-bit-wide CCITT instance checked against an independent bitwise model.
module tb_crc_parallel_gen;

   logic clk;
   logic rst, start, start16;
   logic in_valid, in_last, in_valid16, in_last16, out_ready;
   logic [7:0]  in_data;
   logic [15:0] in_data16;

   logic r0, v0, l0, b0;  logic [7:0] d0;  logic [15:0] c0;
   logic r1, v1, l1, b1;  logic [7:0] d1;  logic [15:0] c1;
   logic r2, v2, l2, b2;  logic [31:0] d2; logic [31:0] c2;
   logic r3, v3, l3, b3;  logic [7:0] d3;  logic [15:0] c3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [32:0] q0[$], q1[$], q2[$], q3[$];
   logic [32:0] e0, e1, e2, e3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   crc_parallel_gen u_ccitt (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r0),
      .in_data(in_data), .in_last(in_last), .out_valid(v0), .out_ready(out_ready),
      .out_data(d0), .out_last(l0), .busy(b0), .crc_value(c0));

   crc_parallel_gen #(.INIT(16'h0000)) u_xmodem (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r1),
      .in_data(in_data), .in_last(in_last), .out_valid(v1), .out_ready(out_ready),
      .out_data(d1), .out_last(l1), .busy(b1), .crc_value(c1));

   crc_parallel_gen #(
      .CRC_W(32), .DATA_W(8), .OUT_W(32), .POLY(32'h04C11DB7),
      .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
      .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_crc32 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r2),
      .in_data(in_data), .in_last(in_last), .out_valid(v2), .out_ready(out_ready),
      .out_data(d2), .out_last(l2), .busy(b2), .crc_value(c2));

   crc_parallel_gen #(.DATA_W(16)) u_wide (
      .clk(clk), .rst(rst), .start(start16), .in_valid(in_valid16), .in_ready(r3),
      .in_data(in_data16), .in_last(in_last16), .out_valid(v3), .out_ready(out_ready),
      .out_data(d3), .out_last(l3), .busy(b3), .crc_value(c3));

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bitwise reference, register kept left-aligned in 32 bits.
   function automatic logic [31:0] crc_model(input int w, input logic [31:0] poly,
         input logic [31:0] init, input logic [31:0] xo, input bit ri, input bit ro,
         input logic [7:0] msg[$]);
      logic [31:0] c, pa, r;
      logic [7:0]  b;
      logic        fb;
      c  = init << (32 - w);
      pa = poly << (32 - w);
      foreach (msg[k]) begin
         b = msg[k];
         for (int j = 0; j < 8; j++) begin
            fb = c[31] ^ (ri ? b[0] : b[7]);
            b  = ri ? (b >> 1) : (b << 1);
            c  = (c << 1) ^ (fb ? pa : 32'h0);
         end
      end
      if (ro) begin
         for (int i = 0; i < 32; i++) r[31 - i] = c[i];
      end else begin
         r = c >> (32 - w);
      end
      return r ^ xo;
   endfunction

   task automatic push_model(input logic [7:0] msg[$]);
      logic [31:0] r;
      r = crc_model(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, msg);
      q0.push_back({1'b0, 24'h0, r[15:8]});
      q0.push_back({1'b1, 24'h0, r[7:0]});
      r = crc_model(16, 32'h1021, 32'h0, 32'h0, 1'b0, 1'b0, msg);
      q1.push_back({1'b0, 24'h0, r[15:8]});
      q1.push_back({1'b1, 24'h0, r[7:0]});
      r = crc_model(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, msg);
      q2.push_back({1'b1, r});
   endtask

   task automatic push_known();
      q0.push_back({1'b0, 32'h29});  q0.push_back({1'b1, 32'hB1});
      q1.push_back({1'b0, 32'h31});  q1.push_back({1'b1, 32'hC3});
      q2.push_back({1'b1, 32'hCBF43926});
   endtask

   // mode: 0 = no last/no push, 1 = model push, 2 = check-vector push, 3 = last without push
   task automatic send_bytes(input logic [7:0] msg[$], input bit gaps, input int mode);
      int g;
      for (int k = 0; k < msg.size(); k++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_data  = msg[k];
         in_last  = (mode != 0) && (k == msg.size() - 1);
         if (in_last && mode == 1) push_model(msg);
         if (in_last && mode == 2) push_known();
         check("in_ready_run", 33'(r0), 33'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (k == 0 && mode == 2) check("xmodem_first_byte", 33'(c1), 33'h2672);
      end
   endtask

   task automatic send_wide(input logic [7:0] msg[$]);
      int g;
      logic [31:0] r;
      for (int k = 0; k < msg.size(); k += 2) begin
         g = $urandom_range(0, 3);
         repeat (g) begin @(posedge clk); #1; end
         in_valid16 = 1'b1;
         in_data16  = {msg[k], msg[k+1]};
         in_last16  = (k + 2 >= msg.size());
         if (in_last16) begin
            r = crc_model(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, msg);
            q3.push_back({1'b0, 24'h0, r[15:8]});
            q3.push_back({1'b1, 24'h0, r[7:0]});
         end
         check("wide_in_ready", 33'(r3), 33'd1);
         @(posedge clk); #1;
         in_valid16 = 1'b0;
         in_last16  = 1'b0;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((b0 || b1 || b2 || b3) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_within_budget", 33'(n < 100), 33'd1);
   endtask

   task automatic wait_final_chunk();
      int n = 0;
      while (!(v0 && l0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("final_chunk_within_budget", 33'(n < 50), 33'd1);
   endtask

   always @(negedge clk) if (!rst && v0 && out_ready) begin
      if (q0.size() == 0) check("ccitt_extra_chunk", 33'(q0.size()), 33'd1);
      else begin e0 = q0.pop_front(); check("ccitt_chunk", {l0, 24'h0, d0}, e0); end
   end
   always @(negedge clk) if (!rst && v1 && out_ready) begin
      if (q1.size() == 0) check("xmodem_extra_chunk", 33'(q1.size()), 33'd1);
      else begin e1 = q1.pop_front(); check("xmodem_chunk", {l1, 24'h0, d1}, e1); end
   end
   always @(negedge clk) if (!rst && v2 && out_ready) begin
      if (q2.size() == 0) check("crc32_extra_chunk", 33'(q2.size()), 33'd1);
      else begin e2 = q2.pop_front(); check("crc32_chunk", {l2, d2}, e2); end
   end
   always @(negedge clk) if (!rst && v3 && out_ready) begin
      if (q3.size() == 0) check("wide_extra_chunk", 33'(q3.size()), 33'd1);
      else begin e3 = q3.pop_front(); check("wide_chunk", {l3, 24'h0, d3}, e3); end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] chk[$];
      logic [7:0] pre[$];
      logic [7:0] m8[$];
      logic [7:0] rnd[$];
      int len;
      chk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      m8  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
      pre = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

      rst = 1'b1; start = 1'b0; start16 = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      in_valid16 = 1'b0; in_last16 = 1'b0; in_data16 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 33'(r0), 33'd0);
      check("rst_out_valid", 33'(v0), 33'd0);
      check("rst_out_last", 33'(l0), 33'd0);
      check("rst_out_data", 33'(d0), 33'd0);
      check("rst_busy", 33'(b0), 33'd0);
      check("rst_crc_ccitt", 33'(c0), 33'hFFFF);
      check("rst_crc_xmodem", 33'(c1), 33'h0);
      check("rst_crc32", 33'(c2), 33'hFFFFFFFF);
      rst = 1'b0;
      @(posedge clk); #1;

      // Check vector, no backpressure; busy falls right after the last chunk.
      do_start();
      check("start_busy", 33'(b0), 33'd1);
      send_bytes(chk, 1'b0, 2);
      check("latency_out_valid", 33'(v0), 33'd1);
      check("emit_in_ready", 33'(r0), 33'd0);
      wait_final_chunk();
      @(posedge clk); #1;
      check("busy_after_last", 33'(b0), 33'd0);
      check("valid_after_last", 33'(v0), 33'd0);
      wait_idle();

      // Output backpressure holds chunk 0 stable.
      do_start();
      out_ready = 1'b0;
      send_bytes(chk, 1'b0, 2);
      repeat (5) begin
         check("stall_valid", 33'(v0), 33'd1);
         check("stall_data", 33'(d0), 33'h29);
         check("stall_in_ready", 33'(r0), 33'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_idle();

      // Mid-frame restart; the beat in the restart cycle is discarded.
      do_start();
      send_bytes(pre, 1'b0, 0);
      start = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("restart_stays_run", 33'(r0), 33'd1);
      check("restart_crc_init", 33'(c0), 33'hFFFF);
      send_bytes(chk, 1'b0, 2);
      wait_idle();

      // Gapped 8-bit frame and the same bytes through the 16-bit engine.
      do_start();
      send_bytes(m8, 1'b1, 1);
      wait_idle();
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      send_wide(m8);
      wait_idle();

      // Random frames.
      for (int f = 0; f < 4; f++) begin
         len = $urandom_range(1, 6);
         rnd.delete();
         for (int i = 0; i < len; i++) rnd.push_back(8'($urandom));
         do_start();
         send_bytes(rnd, 1'b1, 1);
         wait_idle();
         rnd.delete();
         for (int i = 0; i < 2 * len; i++) rnd.push_back(8'($urandom));
         start16 = 1'b1;
         @(posedge clk); #1;
         start16 = 1'b0;
         send_wide(rnd);
         wait_idle();
      end

      // Back-to-back: start together with the final output handshake.
      do_start();
      send_bytes(chk, 1'b0, 2);
      wait_final_chunk();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", 33'(b0), 33'd1);
      check("b2b_in_ready", 33'(r0), 33'd1);
      check("b2b_valid_low", 33'(v0), 33'd0);
      send_bytes(chk, 1'b0, 2);
      wait_idle();

      // Reset during EMIT discards the result.
      do_start();
      out_ready = 1'b0;
      send_bytes(chk, 1'b0, 3);
      check("pre_rst_valid", 33'(v0), 33'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_valid", 33'(v0), 33'd0);
      check("post_rst_busy", 33'(b0), 33'd0);
      check("post_rst_crc", 33'(c0), 33'hFFFF);
      check("post_rst_in_ready", 33'(r0), 33'd0);
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      do_start();
      send_bytes(chk, 1'b0, 2);
      wait_idle();

      repeat (3) begin @(posedge clk); #1; end
      check("ccitt_drained", 33'(q0.size()), 33'd0);
      check("xmodem_drained", 33'(q1.size()), 33'd0);
      check("crc32_drained", 33'(q2.size()), 33'd0);
      check("wide_drained", 33'(q3.size()), 33'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
